// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready holding register with framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [1:0]       sync_reg;
    logic             rx_s;
    logic [2:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             complete_reg;
    logic             framing_error_reg;
    logic [7:0]       data_reg;
    logic             data_valid_reg;
    logic             overrun_reg;

    // Both stages reset high so a reset never looks like a start edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    sync_reg[gi] <= rx;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            bit_idx_reg       <= 3'd0;
            shift_reg         <= 8'd0;
            complete_reg      <= 1'b0;
            framing_error_reg <= 1'b0;
        end else begin
            complete_reg      <= 1'b0;
            framing_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= 3'd0;
                        state_reg   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            complete_reg <= 1'b1;
                            state_reg    <= IDLE;
                        end else begin
                            framing_error_reg <= 1'b1;
                            state_reg         <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A break must end before another start edge is accepted.
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A new byte wins over a same-cycle handshake; otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg       <= 8'd0;
            data_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (complete_reg) begin
                if (!data_valid_reg || data_ready) begin
                    data_reg       <= shift_reg;
                    data_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (data_valid_reg && data_ready) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    assign data          = data_reg;
    assign data_valid    = data_valid_reg;
    assign overrun       = overrun_reg;
    assign framing_error = framing_error_reg;
    assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 104 clocks per bit: byte reception, stream,
// glitch rejection, framing error, overrun and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int busy_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] cap_q[$];

    uart_rx dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .data          (data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (data_valid && !prev_valid) rise_cyc <= cyc;
        if (data_valid && data_ready) cap_q.push_back(data);
        prev_valid <= data_valid;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives start and data bits, then leaves rx at the stop level and returns.
    task automatic send_bits(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
    endtask

    task automatic frame(input logic [7:0] b);
        send_bits(b, 1'b1);
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    initial begin
        int base;
        int f0;
        int o0;
        int b0;
        logic [7:0] hello[6];
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C;
        hello[3] = 8'h4C; hello[4] = 8'h4F; hello[5] = 8'h0A;

        repeat (5) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'h0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fe", {31'd0, framing_error}, 32'd0);
        check("rst_ov", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 1: single byte held until consumed
        frame(8'h48);
        repeat (2) @(negedge clk);
        check("t1_valid", {31'd0, data_valid}, 32'd1);
        check("t1_data", {24'd0, data}, 32'h48);
        check("t1_latency_ok", {31'd0, (rise_cyc - start_cyc >= 988) && (rise_cyc - start_cyc <= 996)}, 32'd1);
        repeat (20) @(negedge clk);
        check("t1_held_valid", {31'd0, data_valid}, 32'd1);
        check("t1_held_data", {24'd0, data}, 32'h48);
        check("t1_idle", {31'd0, busy}, 32'd0);
        pulse_ready();
        check("t1_cleared", {31'd0, data_valid}, 32'd0);

        // 2: back-to-back "HELLO\n" with ready tied high
        repeat (5) @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        base = cap_q.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        for (int i = 0; i < 6; i++) frame(hello[i]);
        repeat (20) @(negedge clk);
        check("t2_count", cap_q.size() - base, 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("t2_byte%0d", i), {24'd0, cap_q[base+i]}, {24'd0, hello[i]});
        check("t2_no_fe", fe_cnt - f0, 32'd0);
        check("t2_no_ov", ov_cnt - o0, 32'd0);

        // 3: 20-cycle low glitch is rejected at the start-bit sample
        base = cap_q.size();
        b0 = busy_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("t3_busy_len_ok", {31'd0, (busy_cnt - b0 >= 50) && (busy_cnt - b0 <= 56)}, 32'd1);
        check("t3_no_byte", cap_q.size() - base, 32'd0);
        check("t3_no_fe", fe_cnt - f0, 32'd0);
        check("t3_idle", {31'd0, busy}, 32'd0);

        // 4: stop bit low plus a 3-bit break, then a clean byte
        base = cap_q.size();
        send_bits(8'h55, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("t4_fe_once", fe_cnt - f0, 32'd1);
        check("t4_no_byte", cap_q.size() - base, 32'd0);
        check("t4_valid_low", {31'd0, data_valid}, 32'd0);
        frame(8'hA3);
        repeat (10) @(negedge clk);
        check("t4_recovered_count", cap_q.size() - base, 32'd1);
        check("t4_recovered_data", {24'd0, cap_q[base]}, 32'hA3);
        check("t4_fe_total", fe_cnt - f0, 32'd1);

        // 5: overrun keeps the old byte; ready on the load cycle takes the new one
        data_ready = 1'b0;
        o0 = ov_cnt;
        frame(8'h11);
        frame(8'h22);
        repeat (10) @(negedge clk);
        check("t5_ov_once", ov_cnt - o0, 32'd1);
        check("t5_kept_data", {24'd0, data}, 32'h11);
        check("t5_kept_valid", {31'd0, data_valid}, 32'd1);
        pulse_ready();
        repeat (5) @(negedge clk);
        frame(8'h11);
        repeat (5) @(negedge clk);
        check("t5b_first", {24'd0, data}, 32'h11);
        send_bits(8'h22, 1'b1);
        while (cyc < start_cyc + 991) @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        check("t5b_data", {24'd0, data}, 32'h22);
        check("t5b_valid", {31'd0, data_valid}, 32'd1);
        repeat (CPB) @(negedge clk);
        check("t5b_no_ov", ov_cnt - o0, 32'd1);
        pulse_ready();

        // 6: reset during bit 4 of 0x7E aborts silently
        repeat (5) @(negedge clk);
        f0 = fe_cnt;
        o0 = ov_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx = (8'h7E >> i) & 8'h01;
            repeat ((i == 4) ? CPB / 2 : CPB) @(negedge clk);
        end
        check("t6_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_data", {24'd0, data}, 32'h0);
        check("t6_rst_valid", {31'd0, data_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        rx = 1'b1;
        repeat (CPB * 6) @(negedge clk);
        check("t6_no_valid", {31'd0, data_valid}, 32'd0);
        check("t6_no_fe", fe_cnt - f0, 32'd0);
        check("t6_no_ov", ov_cnt - o0, 32'd0);
        frame(8'h3C);
        repeat (10) @(negedge clk);
        check("t6_next_valid", {31'd0, data_valid}, 32'd1);
        check("t6_next_data", {24'd0, data}, 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
